// File: rtl/nn_wb_pkg.sv
// Shared definitions for the NN Wishbone controller: register map, bit positions and FSM states.
package nn_wb_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_RESULT = 8'h08;
  localparam logic [7:0] OFF_COUNT  = 8'h0C;
  localparam logic [7:0] OFF_OP0    = 8'h10;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_SRC_SEL = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } nn_state_e;

endpackage

// File: rtl/nn_wb_ctrl_if.sv
// Wishbone classic slave bus bundle for the NN controller.
interface nn_wb_ctrl_if;
  // A transfer is offered while stb & cyc are high and is held until ack;
  // the slave answers with a single-cycle ack one clock after accepting it.
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/nn_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level with a rising-edge pulse output.
module nn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // Both terms are flop outputs, so the pulse is clean for one cycle.
  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/nn_wb_ctrl.sv
// Wishbone-mapped controller that loads operands, launches the NN core and collects its result.
module nn_wb_ctrl
  import nn_wb_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          N_OPS       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT_CYC = 1023,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  nn_wb_ctrl_if.slave             wb,
  input  logic [37:0]             io_in,
  output logic [37:0]             io_out,
  output logic [37:0]             io_oeb,
  output logic [N_OPS*DATA_W-1:0] core_ops,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [DATA_W-1:0]       core_result,
  output logic                    irq,
  output nn_state_e               state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int OP_IW = (N_OPS > 1) ? $clog2(N_OPS) : 1;

  nn_state_e state, state_nxt;

  logic [DATA_W-1:0] ops [N_OPS];
  logic [DATA_W-1:0] result;
  logic [15:0]       count;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              irq_en, src_sel;
  logic              st_done, st_tmo;
  logic              ack;

  logic              valid, acc, wr;
  logic [7:0]        off;
  logic [5:0]        word_off, op_off;
  logic              op_hit;
  logic [OP_IW-1:0]  op_idx;
  logic              ctrl_wr, stat_wr, op_wr;
  logic              wb_start, sw_start, sw_rise;
  logic              tmo_last, cap, done_set, tmo_set;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign valid    = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign acc      = valid & ~ack;
  assign wr       = acc & wb.wbs_we_i;
  assign off      = {wb.wbs_adr_i[7:2], 2'b00};
  assign word_off = wb.wbs_adr_i[7:2];
  assign op_off   = word_off - OFF_OP0[7:2];
  assign op_hit   = (word_off >= OFF_OP0[7:2]) && (op_off < 6'(N_OPS));
  assign op_idx   = op_off[OP_IW-1:0];

  assign ctrl_wr  = wr & (off == OFF_CTRL) & wb.wbs_sel_i[0];
  assign stat_wr  = wr & (off == OFF_STATUS) & wb.wbs_sel_i[0];
  assign op_wr    = wr & op_hit & (state == S_IDLE);

  // The start source is chosen by the src_sel value already in CTRL.
  assign wb_start = ctrl_wr & wb.wbs_dat_i[CTRL_START] & ~src_sel;
  assign sw_start = sw_rise & src_sel;
  assign tmo_last = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  assign unused_bits = ^{io_in[37:33], io_in[31:0], wb.wbs_adr_i[1:0]};

  nn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (io_in[32]),
    .rise (sw_rise)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    cap        = 1'b0;
    done_set   = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      S_IDLE:  if (wb_start | sw_start) state_nxt = S_START;
      S_START: begin
        core_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          cap       = 1'b1;
          state_nxt = S_DONE;
        end else if (tmo_last) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        done_set  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 32'b0;
    case (off)
      OFF_CTRL:   rd_data = {29'b0, src_sel, irq_en, 1'b0};
      OFF_STATUS: rd_data = {29'b0, st_tmo, st_done, state != S_IDLE};
      OFF_RESULT: rd_data = 32'(result);
      OFF_COUNT:  rd_data = {16'b0, count};
      default:    if (op_hit) rd_data = 32'(ops[op_idx]);
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      ack <= acc;
      if (state == S_START)     tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_dat_o <= 32'b0;
      irq_en       <= 1'b0;
      src_sel      <= 1'b0;
      st_done      <= 1'b0;
      st_tmo       <= 1'b0;
      result       <= '0;
      count        <= 16'b0;
      for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
    end else begin
      wb.wbs_dat_o <= (acc & ~wb.wbs_we_i) ? rd_data : 32'b0;
      if (ctrl_wr) begin
        irq_en  <= wb.wbs_dat_i[CTRL_IRQ_EN];
        src_sel <= wb.wbs_dat_i[CTRL_SRC_SEL];
      end
      // A hardware set in the same cycle as a W1C clear keeps the bit set.
      st_done <= done_set | (st_done & ~(stat_wr & wb.wbs_dat_i[STAT_DONE]));
      st_tmo  <= tmo_set  | (st_tmo  & ~(stat_wr & wb.wbs_dat_i[STAT_TIMEOUT]));
      if (cap)      result <= core_result;
      if (done_set) count  <= count + 16'd1;
      if (op_wr) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (wb.wbs_sel_i[b]) ops[op_idx][8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign wb.wbs_ack_o = ack;
  assign irq          = irq_en & (st_done | st_tmo);
  assign io_out       = {6'b0, 32'(result)};
  assign io_oeb       = {6'b111111, 32'b0};
  assign state_dbg    = state;

  always_comb begin
    core_ops = '0;
    for (int i = 0; i < N_OPS; i++) core_ops[i*DATA_W +: DATA_W] = ops[i];
  end

endmodule

// File: tb/tb_nn_wb_ctrl.sv
// Directed scoreboard bench for nn_wb_ctrl: register map, core handshake, switch start, timeout, reset abort.
module tb_nn_wb_ctrl;
  import nn_wb_pkg::*;

  localparam int          TMO  = 1023;
  localparam int          SYNC = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk;
  logic         rst;
  logic [37:0]  io_in;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;
  logic [127:0] core_ops;
  logic         core_start;
  logic         core_done;
  logic [31:0]  core_result;
  logic         irq;
  nn_state_e    state_dbg;

  nn_wb_ctrl_if wb();

  nn_wb_ctrl #(
    .DATA_W(32), .N_OPS(4), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO), .BASE_ADR(BASE)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (wb),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .core_ops    (core_ops),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .irq         (irq),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          start_cnt = 0;
  bit          core_auto = 0;
  int          core_lat = 5;
  logic [31:0] core_res = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] data,
                         input logic [3:0] sel, input string name);
    int n;
    wb.wbs_adr_i = BASE | {24'b0, off};
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_dat_i = data;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb.wbs_ack_o && n < 8);
    check({name, "_ack_lat"}, 32'(n), 32'd1);
    @(negedge clk); #1;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] sel,
                          input string name);
    wb_xfer(1'b1, off, data, sel, name);
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    wb_xfer(1'b0, off, 32'h0, 4'hF, name);
  endtask

  // scoreboard monitor
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (wb.wbs_ack_o) begin
      check("ack_single", {31'b0, prev_ack}, 32'd0);
      if (!wb.wbs_we_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_read", 32'd1, 32'd0);
        end else begin
          automatic logic [31:0] e = exp_q.pop_front();
          automatic string       s = name_q.pop_front();
          check(s, wb.wbs_dat_o, e);
        end
      end
    end
    prev_ack = wb.wbs_ack_o;
  end

  always @(negedge clk) if (core_start) start_cnt++;

  // NN core model
  initial begin
    core_done   = 1'b0;
    core_result = 32'h0;
    forever begin
      @(negedge clk);
      if (core_start && core_auto) begin
        repeat (core_lat) @(posedge clk);
        #1;
        core_done   = 1'b1;
        core_result = core_res;
        @(posedge clk); #1;
        core_done = 1'b0;
      end
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    int n;
    rst = 1'b1;
    io_in = '0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_dat_i = 32'h0;
    wb.wbs_adr_i = 32'h0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rst_dat", wb.wbs_dat_o, 32'd0);
    check("rst_core_start", {31'b0, core_start}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_io_out", io_out[31:0], 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read(OFF_CTRL,   32'h0, "rst_ctrl");
    wb_read(OFF_STATUS, 32'h0, "rst_status");
    wb_read(OFF_RESULT, 32'h0, "rst_result");
    wb_read(OFF_COUNT,  32'h0, "rst_count");
    wb_read(OFF_OP0,    32'h0, "rst_op0");

    // basic operation: operands 1..4, core answers 0x0A after 5 cycles
    for (int i = 0; i < 4; i++) wb_write(8'(OFF_OP0 + 4*i), 32'(i + 1), 4'hF, "w_op");
    wb_read(8'h18, 32'd3, "op2_readback");
    core_auto = 1; core_lat = 5; core_res = 32'h0A;
    wb_write(OFF_CTRL, 32'h1, 4'hF, "w_ctrl_start");
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check("core_ops", core_ops[32*i +: 32], 32'(i + 1));
    check("basic_starts", 32'(start_cnt), 32'd1);
    wb_read(OFF_RESULT, 32'h0A, "basic_result");
    wb_read(OFF_STATUS, 32'h2,  "basic_status");
    wb_read(OFF_COUNT,  32'h1,  "basic_count");
    wb_read(OFF_CTRL,   32'h0,  "ctrl_start_reads0");
    check("basic_io_out", io_out[31:0], 32'h0A);
    check("io_out_hi", {26'b0, io_out[37:32]}, 32'd0);
    check("io_oeb_lo", io_oeb[31:0], 32'd0);
    check("io_oeb_hi", {26'b0, io_oeb[37:32]}, 32'h3F);
    check("basic_irq_off", {31'b0, irq}, 32'd0);
    wb_write(OFF_STATUS, 32'h2, 4'hF, "w_clr_done");
    wb_read(OFF_STATUS, 32'h0, "done_cleared");

    // busy writes ignored, then timeout with irq
    core_auto = 0;
    wb_write(OFF_CTRL, 32'h2, 4'hF, "w_irq_en");
    snap = start_cnt;
    wb_write(OFF_CTRL, 32'h3, 4'hF, "w_start_tmo");
    wb_read(OFF_STATUS, 32'h1, "busy_status");
    wb_write(OFF_OP0, 32'hFF, 4'hF, "w_op0_busy");
    wb_write(OFF_CTRL, 32'h3, 4'hF, "w_start_busy");
    wb_read(OFF_OP0, 32'h1, "op0_unchanged");
    check("busy_single_start", 32'(start_cnt - snap), 32'd1);
    check("busy_irq_off", {31'b0, irq}, 32'd0);
    repeat (TMO - 40) @(posedge clk);
    #1;
    wb_read(OFF_STATUS, 32'h1, "tmo_not_early");
    repeat (60) @(posedge clk);
    #1;
    wb_read(OFF_STATUS, 32'h4,  "tmo_status");
    wb_read(OFF_RESULT, 32'h0A, "tmo_result_kept");
    wb_read(OFF_COUNT,  32'h1,  "tmo_count_kept");
    check("tmo_irq", {31'b0, irq}, 32'd1);
    check("tmo_state", 32'(state_dbg), 32'(S_IDLE));
    wb_write(OFF_STATUS, 32'h4, 4'hF, "w_clr_tmo");
    wb_read(OFF_STATUS, 32'h0, "tmo_cleared");
    check("tmo_irq_cleared", {31'b0, irq}, 32'd0);

    // switch start: one pulse, SYNC+1..SYNC+2 cycles latency
    wb_write(OFF_CTRL, 32'h4, 4'hF, "w_src_sw");
    core_auto = 1; core_lat = 3; core_res = 32'h55;
    snap = start_cnt;
    @(posedge clk); #1;
    io_in[32] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!core_start && n < 12);
    check("sw_latency_in_range", {31'b0, (n >= SYNC + 1 && n <= SYNC + 2)}, 32'd1);
    if (n < 10) repeat (10 - n) @(posedge clk);
    #1;
    io_in[32] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("sw_single_start", 32'(start_cnt - snap), 32'd1);
    wb_read(OFF_RESULT, 32'h55, "sw_result");
    wb_read(OFF_COUNT,  32'h2,  "sw_count");
    wb_read(OFF_STATUS, 32'h2,  "sw_status");
    check("sw_io_out", io_out[31:0], 32'h55);
    snap = start_cnt;
    wb_write(OFF_CTRL, 32'h5, 4'hF, "w_wbstart_src_sw");
    repeat (5) @(posedge clk);
    #1;
    check("wbstart_ignored_src_sw", 32'(start_cnt - snap), 32'd0);

    // map boundaries and byte enables
    wb_read(8'h40, 32'h0, "unmapped_read");
    wb_write(8'h40, 32'h12345678, 4'hF, "w_unmapped");
    wb_read(8'h40, 32'h0, "unmapped_after_write");
    wb_write(8'h14, 32'hAABBCCDD, 4'b0001, "w_op1_byte0");
    wb_read(8'h14, 32'h000000DD, "op1_byte0");
    wb_write(8'h1C, 32'h11223344, 4'b1100, "w_op3_upper");
    wb_read(8'h1C, 32'h11220004, "op3_upper");
    wb_write(OFF_COUNT, 32'h1234, 4'hF, "w_count_ro");
    wb_read(OFF_COUNT, 32'h2, "count_ro");

    // reset while waiting on the core, then a stale done
    core_auto = 0;
    wb_write(OFF_CTRL, 32'h0, 4'hF, "w_src_wb");
    wb_write(OFF_CTRL, 32'h1, 4'hF, "w_start_abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_wait", 32'(state_dbg), 32'(S_WAIT));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    core_done   = 1'b1;
    core_result = 32'h77;
    @(posedge clk); #1;
    core_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_state", 32'(state_dbg), 32'(S_IDLE));
    wb_read(OFF_STATUS, 32'h0, "abort_status");
    wb_read(OFF_COUNT,  32'h0, "abort_count");
    wb_read(OFF_RESULT, 32'h0, "abort_result");
    wb_read(8'h14,      32'h0, "abort_op1");

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
